// File: rtl/afu_engine_mux.sv
// Shares one memory read channel and one memory write channel among N_ENG engines:
// round-robin request arbitration, tag-based response routing, outstanding tracking.
module afu_engine_mux #(
  parameter int unsigned N_ENG   = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned TAG_W   = 14,
  parameter int unsigned MAX_OUT = 16,
  localparam int unsigned IDX_W  = $clog2(N_ENG),
  localparam int unsigned ETAG_W = TAG_W - IDX_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_ENG-1:0]          eng_rd_valid,
  input  logic [N_ENG*ADDR_W-1:0]   eng_rd_addr,
  input  logic [N_ENG*ETAG_W-1:0]   eng_rd_tag,
  output logic [N_ENG-1:0]          eng_rd_ready,
  output logic                      mem_rd_valid,
  output logic [ADDR_W-1:0]         mem_rd_addr,
  output logic [TAG_W-1:0]          mem_rd_tag,
  input  logic                      mem_rd_almfull,
  input  logic                      mem_rd_rsp_valid,
  input  logic [TAG_W-1:0]          mem_rd_rsp_tag,
  input  logic [DATA_W-1:0]         mem_rd_rsp_data,
  output logic [N_ENG-1:0]          eng_rd_rsp_valid,
  output logic [ETAG_W-1:0]         eng_rd_rsp_tag,
  output logic [DATA_W-1:0]         eng_rd_rsp_data,
  input  logic [N_ENG-1:0]          eng_wr_valid,
  input  logic [N_ENG*ADDR_W-1:0]   eng_wr_addr,
  input  logic [N_ENG*DATA_W-1:0]   eng_wr_data,
  input  logic [N_ENG*ETAG_W-1:0]   eng_wr_tag,
  output logic [N_ENG-1:0]          eng_wr_ready,
  output logic                      mem_wr_valid,
  output logic [ADDR_W-1:0]         mem_wr_addr,
  output logic [DATA_W-1:0]         mem_wr_data,
  output logic [TAG_W-1:0]          mem_wr_tag,
  input  logic                      mem_wr_almfull,
  input  logic                      mem_wr_rsp_valid,
  input  logic [TAG_W-1:0]          mem_wr_rsp_tag,
  output logic [N_ENG-1:0]          eng_wr_rsp_valid,
  output logic [ETAG_W-1:0]         eng_wr_rsp_tag,
  input  logic [N_ENG-1:0]          eng_done,
  output logic                      all_done,
  output logic                      rsp_err
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);
  typedef logic [CW-1:0] cnt_t;

  // First eligible engine at or after ptr, wrapping; result is one-hot or zero.
  function automatic logic [N_ENG-1:0] rr_pick(input logic [N_ENG-1:0] elig,
                                              input logic [IDX_W-1:0] ptr);
    logic [N_ENG-1:0] gnt;
    gnt = '0;
    for (int unsigned k = 0; k < N_ENG; k++) begin
      for (int unsigned i = 0; i < N_ENG; i++) begin
        if (gnt == '0 && elig[i] && i == (32'(ptr) + k) % N_ENG) gnt[i] = 1'b1;
      end
    end
    return gnt;
  endfunction

  function automatic logic [IDX_W-1:0] enc(input logic [N_ENG-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N_ENG; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    return (32'(idx) == N_ENG - 1) ? '0 : idx + 1'b1;
  endfunction

  cnt_t             rd_cnt_q [N_ENG];
  cnt_t             rd_cnt_d [N_ENG];
  cnt_t             wr_cnt_q [N_ENG];
  cnt_t             wr_cnt_d [N_ENG];
  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;

  logic [N_ENG-1:0]  rd_elig, rd_gnt, rd_rsp_oh;
  logic [IDX_W-1:0]  rd_idx, rd_rsp_idx;
  logic [ADDR_W-1:0] rd_sel_addr;
  logic [ETAG_W-1:0] rd_sel_tag;
  logic              rd_rsp_hit, rd_rsp_ok, rd_err;

  logic [N_ENG-1:0]  wr_elig, wr_gnt, wr_rsp_oh;
  logic [IDX_W-1:0]  wr_idx, wr_rsp_idx;
  logic [ADDR_W-1:0] wr_sel_addr;
  logic [DATA_W-1:0] wr_sel_data;
  logic [ETAG_W-1:0] wr_sel_tag;
  logic              wr_rsp_hit, wr_rsp_ok, wr_err;

  logic              cnt_zero;

  logic              mem_rd_valid_q, mem_wr_valid_q;
  logic [ADDR_W-1:0] mem_rd_addr_q, mem_wr_addr_q;
  logic [TAG_W-1:0]  mem_rd_tag_q, mem_wr_tag_q;
  logic [DATA_W-1:0] mem_wr_data_q;
  logic [N_ENG-1:0]  eng_rd_rsp_valid_q, eng_wr_rsp_valid_q;
  logic [ETAG_W-1:0] eng_rd_rsp_tag_q, eng_wr_rsp_tag_q;
  logic [DATA_W-1:0] eng_rd_rsp_data_q;
  logic              all_done_q, rsp_err_q;

  always_comb begin
    rd_elig     = '0;
    rd_sel_addr = '0;
    rd_sel_tag  = '0;
    rd_rsp_oh   = '0;
    rd_rsp_hit  = 1'b0;
    rd_rsp_idx  = mem_rd_rsp_tag[TAG_W-1:ETAG_W];
    for (int unsigned i = 0; i < N_ENG; i++) begin
      rd_elig[i] = eng_rd_valid[i] && !mem_rd_almfull && !reset && (rd_cnt_q[i] < CW'(MAX_OUT));
    end
    rd_gnt   = rr_pick(rd_elig, rd_ptr_q);
    rd_idx   = enc(rd_gnt);
    rd_ptr_d = (rd_gnt != '0) ? next_ptr(rd_idx) : rd_ptr_q;
    for (int unsigned i = 0; i < N_ENG; i++) begin
      if (rd_gnt[i]) begin
        rd_sel_addr = eng_rd_addr[i*ADDR_W +: ADDR_W];
        rd_sel_tag  = eng_rd_tag[i*ETAG_W +: ETAG_W];
      end
      if (rd_rsp_idx == IDX_W'(i) && rd_cnt_q[i] != '0) rd_rsp_hit = 1'b1;
    end
    // Out-of-range indices never match any engine, so they fall into the error path.
    rd_rsp_ok = mem_rd_rsp_valid && rd_rsp_hit;
    rd_err    = mem_rd_rsp_valid && !rd_rsp_hit;
    for (int unsigned i = 0; i < N_ENG; i++) begin
      rd_rsp_oh[i] = rd_rsp_ok && (rd_rsp_idx == IDX_W'(i));
      rd_cnt_d[i]  = rd_cnt_q[i] + {{(CW-1){1'b0}}, rd_gnt[i]} - {{(CW-1){1'b0}}, rd_rsp_oh[i]};
    end
  end

  always_comb begin
    wr_elig     = '0;
    wr_sel_addr = '0;
    wr_sel_data = '0;
    wr_sel_tag  = '0;
    wr_rsp_oh   = '0;
    wr_rsp_hit  = 1'b0;
    wr_rsp_idx  = mem_wr_rsp_tag[TAG_W-1:ETAG_W];
    for (int unsigned i = 0; i < N_ENG; i++) begin
      wr_elig[i] = eng_wr_valid[i] && !mem_wr_almfull && !reset && (wr_cnt_q[i] < CW'(MAX_OUT));
    end
    wr_gnt   = rr_pick(wr_elig, wr_ptr_q);
    wr_idx   = enc(wr_gnt);
    wr_ptr_d = (wr_gnt != '0) ? next_ptr(wr_idx) : wr_ptr_q;
    for (int unsigned i = 0; i < N_ENG; i++) begin
      if (wr_gnt[i]) begin
        wr_sel_addr = eng_wr_addr[i*ADDR_W +: ADDR_W];
        wr_sel_data = eng_wr_data[i*DATA_W +: DATA_W];
        wr_sel_tag  = eng_wr_tag[i*ETAG_W +: ETAG_W];
      end
      if (wr_rsp_idx == IDX_W'(i) && wr_cnt_q[i] != '0) wr_rsp_hit = 1'b1;
    end
    wr_rsp_ok = mem_wr_rsp_valid && wr_rsp_hit;
    wr_err    = mem_wr_rsp_valid && !wr_rsp_hit;
    for (int unsigned i = 0; i < N_ENG; i++) begin
      wr_rsp_oh[i] = wr_rsp_ok && (wr_rsp_idx == IDX_W'(i));
      wr_cnt_d[i]  = wr_cnt_q[i] + {{(CW-1){1'b0}}, wr_gnt[i]} - {{(CW-1){1'b0}}, wr_rsp_oh[i]};
    end
  end

  always_comb begin
    cnt_zero = 1'b1;
    for (int unsigned i = 0; i < N_ENG; i++) begin
      if (rd_cnt_q[i] != '0 || wr_cnt_q[i] != '0) cnt_zero = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_ENG; i++) begin
        rd_cnt_q[i] <= '0;
        wr_cnt_q[i] <= '0;
      end
      rd_ptr_q           <= '0;
      wr_ptr_q           <= '0;
      mem_rd_valid_q     <= 1'b0;
      mem_rd_addr_q      <= '0;
      mem_rd_tag_q       <= '0;
      mem_wr_valid_q     <= 1'b0;
      mem_wr_addr_q      <= '0;
      mem_wr_data_q      <= '0;
      mem_wr_tag_q       <= '0;
      eng_rd_rsp_valid_q <= '0;
      eng_rd_rsp_tag_q   <= '0;
      eng_rd_rsp_data_q  <= '0;
      eng_wr_rsp_valid_q <= '0;
      eng_wr_rsp_tag_q   <= '0;
      all_done_q         <= 1'b0;
      rsp_err_q          <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_ENG; i++) begin
        rd_cnt_q[i] <= rd_cnt_d[i];
        wr_cnt_q[i] <= wr_cnt_d[i];
      end
      rd_ptr_q           <= rd_ptr_d;
      wr_ptr_q           <= wr_ptr_d;
      mem_rd_valid_q     <= (rd_gnt != '0);
      mem_rd_addr_q      <= rd_sel_addr;
      mem_rd_tag_q       <= {rd_idx, rd_sel_tag};
      mem_wr_valid_q     <= (wr_gnt != '0);
      mem_wr_addr_q      <= wr_sel_addr;
      mem_wr_data_q      <= wr_sel_data;
      mem_wr_tag_q       <= {wr_idx, wr_sel_tag};
      eng_rd_rsp_valid_q <= rd_rsp_oh;
      eng_rd_rsp_tag_q   <= mem_rd_rsp_tag[ETAG_W-1:0];
      eng_rd_rsp_data_q  <= mem_rd_rsp_data;
      eng_wr_rsp_valid_q <= wr_rsp_oh;
      eng_wr_rsp_tag_q   <= mem_wr_rsp_tag[ETAG_W-1:0];
      all_done_q         <= (&eng_done) && cnt_zero;
      rsp_err_q          <= rsp_err_q || rd_err || wr_err;
    end
  end

  assign eng_rd_ready     = rd_gnt;
  assign eng_wr_ready     = wr_gnt;
  assign mem_rd_valid     = mem_rd_valid_q;
  assign mem_rd_addr      = mem_rd_addr_q;
  assign mem_rd_tag       = mem_rd_tag_q;
  assign mem_wr_valid     = mem_wr_valid_q;
  assign mem_wr_addr      = mem_wr_addr_q;
  assign mem_wr_data      = mem_wr_data_q;
  assign mem_wr_tag       = mem_wr_tag_q;
  assign eng_rd_rsp_valid = eng_rd_rsp_valid_q;
  assign eng_rd_rsp_tag   = eng_rd_rsp_tag_q;
  assign eng_rd_rsp_data  = eng_rd_rsp_data_q;
  assign eng_wr_rsp_valid = eng_wr_rsp_valid_q;
  assign eng_wr_rsp_tag   = eng_wr_rsp_tag_q;
  assign all_done         = all_done_q;
  assign rsp_err          = rsp_err_q;

endmodule

// File: doc/afu_engine_mux.md
Name: afu_engine_mux

Overview:
- Multiplexes N_ENG identical AFU engines onto one shared memory read channel and one shared memory write channel.
- Sits between the engine array and the CCI request/response path.
- Arbitrates requests round-robin and embeds the engine index in the request tag.
- Routes responses back by tag, tracks per-engine outstanding requests, and aggregates per-engine completion into a single done status.

Parameters:
N_ENG, 4, number of engines (>=2); IDX_W = $clog2(N_ENG)
ADDR_W, 32, cache-line address width
DATA_W, 512, cache-line data width
TAG_W, 14, memory-side tag width; engine tag width ETAG_W = TAG_W-IDX_W
MAX_OUT, 16, max outstanding reads (and separately writes) per engine; counters are $clog2(MAX_OUT+1) bits

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
eng_rd_valid  in  N_ENG  per-engine read request
eng_rd_addr  in  N_ENG*ADDR_W  read addresses, engine i at slice i
eng_rd_tag  in  N_ENG*ETAG_W  engine-local read tags
eng_rd_ready  out  N_ENG  read request accepted this cycle
mem_rd_valid  out  1  read request to memory
mem_rd_addr  out  ADDR_W  read address
mem_rd_tag  out  TAG_W  {engine index, engine tag}
mem_rd_almfull  in  1  memory read channel almost full
mem_rd_rsp_valid  in  1  read response
mem_rd_rsp_tag  in  TAG_W  read response tag
mem_rd_rsp_data  in  DATA_W  read response data
eng_rd_rsp_valid  out  N_ENG  one-hot read response strobe
eng_rd_rsp_tag  out  ETAG_W  engine tag, shared by all engines
eng_rd_rsp_data  out  DATA_W  response data, shared by all engines
eng_wr_valid, eng_wr_addr, eng_wr_data (N_ENG*DATA_W), eng_wr_tag, eng_wr_ready  write-side equivalents of the read request ports
mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_tag, mem_wr_almfull  write-side equivalents of the memory read request ports
mem_wr_rsp_valid, mem_wr_rsp_tag  in  write response (no data)
eng_wr_rsp_valid  out  N_ENG  one-hot write response strobe
eng_wr_rsp_tag  out  ETAG_W  engine tag of write response
eng_done  in  N_ENG  engine reports its work is complete
all_done  out  1  all engines done and nothing outstanding
rsp_err  out  1  sticky: response for an engine with zero outstanding

Behaviour:
Reset:
- All outputs are 0.
- All counters are 0.
- Both round-robin pointers are 0.
- Asserting reset mid-operation discards all in-flight state; responses arriving after reset are dropped.

Read and write request paths (independent, same rules):
- Engine i is eligible when eng_x_valid[i], and !mem_x_almfull, and out_cnt_x[i] < MAX_OUT.
- The grant goes to the first eligible engine at or after the pointer, wrapping at N_ENG.
- eng_x_ready is combinational and one-hot (or zero).
- When engine i is granted, the pointer moves to i+1 mod N_ENG; otherwise the pointer holds.
- The granted request is registered: mem_x_valid, addr, data, and tag = {i[IDX_W-1:0], eng tag} appear the next cycle.
- Request latency is 1 cycle; mem_x_valid is 0 in any cycle following no grant.
- almfull has no bypass: when almfull is high in cycle t, no grant occurs in cycle t.

Outstanding counters (separate read and write sets):
- The counter increments in the cycle the grant occurs.
- It decrements on a memory response whose tag index is i.
- Simultaneous increment and decrement leaves the counter unchanged.
- The counter never exceeds MAX_OUT.

Response routing:
- Responses are registered, with 1 cycle latency.
- eng_x_rsp_valid[idx] = 1, where idx = rsp_tag[TAG_W-1:ETAG_W].
- The engine tag is rsp_tag[ETAG_W-1:0]; read data passes through unchanged.
- A response with idx >= N_ENG, or for a counter already at 0, is dropped: no strobe, the counter is unchanged, and rsp_err is set.
- rsp_err is cleared only by reset.

Done status:
- all_done is registered: all_done = &eng_done AND all read and write counters are 0.
- all_done deasserts the cycle after any condition fails.

Test Plan:
1. Reset, then idle -> all outputs 0; all_done=0 while eng_done=0; set eng_done=4'hF -> all_done=1 one cycle later.
2. All 4 engines hold eng_rd_valid, almfull=0 -> grants 0,1,2,3,0 on consecutive cycles; mem_rd_tag upper 2 bits follow one cycle later; engine 2 tag 0x15 -> mem_rd_tag=14'h2015.
3. mem_rd_almfull=1 for 3 cycles with requests pending -> no grants, mem_rd_valid=0; deassert -> grant resumes at the held pointer.
4. Engine 1 issues 16 reads with no responses -> 17th request is not granted while other engines are still granted; one response with tag 14'h1003 -> eng_rd_rsp_valid=4'b0010, eng_rd_rsp_tag=0x003, next request from engine 1 granted.
5. Grant and response for engine 0 in the same cycle at count 5 -> count stays 5; write response tag index 3 while engine 3 count is 0 -> no strobe, rsp_err=1 and sticky.
6. Assert reset with 8 reads outstanding -> counters 0, rsp_err 0, pointer 0; late responses after reset are dropped and all_done asserts when eng_done=4'hF.
